// File: rtl/cordic_sincos.sv
// Iterative CORDIC sine/cosine with IEEE-754 single in/out, packaged as a multi-cycle
// custom instruction with busy/done handshake and clk_en stall.
module cordic_sincos #(
  parameter int unsigned FRACS = 22,
  parameter int unsigned INTS  = 1,
  parameter int unsigned ITERS = FRACS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic        n,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  localparam int unsigned WIDTH = INTS + FRACS + 1;
  localparam int unsigned CNT_W = 5;
  // Fraction window for packing: at least 23 bits so the mantissa slice is always in range.
  localparam int unsigned MW    = (WIDTH - 1 > 23) ? WIDTH - 1 : 23;

  localparam real K_REAL    = 0.6072529350;
  localparam real PIO2_REAL = 1.5707963267948966;
  localparam int  K_INT     = $rtoi(K_REAL * (2.0 ** FRACS) + 0.5);
  localparam int  PIO2_INT  = $rtoi(PIO2_REAL * (2.0 ** FRACS) + 0.5);

  localparam logic signed [WIDTH-1:0] K_FX    = WIDTH'(K_INT);
  localparam logic signed [WIDTH-1:0] PIO2_FX = WIDTH'(PIO2_INT);
  localparam logic        [63:0]      PIO2_W  = 64'(PIO2_INT);

  // atan(2^-i) in Q0.30, truncated. For i >= 10 the cubic term is below one LSB.
  function automatic logic [31:0] atan_q30(input int unsigned i);
    case (i)
      0:       return 32'h3243F6A8;
      1:       return 32'h1DAC6705;
      2:       return 32'h0FADBAFC;
      3:       return 32'h07F56EA6;
      4:       return 32'h03FEAB76;
      5:       return 32'h01FFD55B;
      6:       return 32'h00FFFAAA;
      7:       return 32'h007FFF55;
      8:       return 32'h003FFFEA;
      9:       return 32'h001FFFFD;
      default: return (i < 30) ? ((32'd1 << (30 - i)) - 32'd1) : 32'd0;
    endcase
  endfunction

  typedef enum logic [1:0] {StIdle, StIter, StPack, StDone} state_e;

  state_e                    state_q;
  logic        [CNT_W-1:0]   cnt_q;
  logic                      mode_q;
  logic signed [WIDTH-1:0]   x_q, y_q, z_q;

  // Float -> fixed conversion of the incoming angle.
  logic        [23:0]        in_mant;
  logic        [63:0]        in_wide;
  logic signed [WIDTH-1:0]   theta_fx;
  int                        in_sh;

  always_comb begin
    in_mant = {1'b1, dataa[22:0]};
    in_sh   = int'(dataa[30:23]) - 150 + int'(FRACS);
    if (in_sh >= 0) in_wide = {40'd0, in_mant} << unsigned'(in_sh);
    else            in_wide = {40'd0, in_mant} >> unsigned'(-in_sh);

    if (dataa[30:23] == 8'd0) begin
      theta_fx = '0;
    end else if (dataa[30:23] == 8'hFF) begin
      if (dataa[22:0] != 23'd0) theta_fx = '0;
      else                      theta_fx = dataa[31] ? -PIO2_FX : PIO2_FX;
    end else if ((int'(dataa[30:23]) - 127 >= int'(INTS)) || (in_wide >= PIO2_W)) begin
      theta_fx = dataa[31] ? -PIO2_FX : PIO2_FX;
    end else begin
      theta_fx = dataa[31] ? -WIDTH'(in_wide) : WIDTH'(in_wide);
    end
  end

  logic signed [WIDTH-1:0] x_sh, y_sh, atan_cur;

  always_comb begin
    x_sh     = x_q >>> cnt_q;
    y_sh     = y_q >>> cnt_q;
    atan_cur = WIDTH'(atan_q30(32'(cnt_q)) >> (30 - FRACS));
  end

  // Fixed -> float packing of the selected rotation component.
  logic signed [WIDTH-1:0] pk_v;
  logic        [WIDTH-1:0] pk_mag;
  logic        [7:0]       pk_lead;
  logic        [7:0]       pk_exp;
  logic        [MW-1:0]    pk_frac;
  logic        [31:0]      pk_float;

  always_comb begin
    pk_v    = mode_q ? y_q : x_q;
    // Two's-complement negate maps -2^(WIDTH-1) onto the unsigned pattern 2^(WIDTH-1).
    pk_mag  = pk_v[WIDTH-1] ? WIDTH'(-pk_v) : pk_v;
    pk_lead = 8'd0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (pk_mag[i]) pk_lead = 8'(i);
    end
    // Shift the leading one to bit MW of the wide intermediate; the cast drops it.
    pk_frac  = MW'((MW + 1)'(pk_mag) << (MW - 32'(pk_lead)));
    pk_exp   = 8'(32'd127 + 32'(pk_lead) - 32'(FRACS));
    pk_float = (pk_mag == '0) ? 32'd0 : {pk_v[WIDTH-1], pk_exp, pk_frac[MW-1 -: 23]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      result  <= 32'd0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x_q     <= K_FX;
            y_q     <= '0;
            z_q     <= theta_fx;
            cnt_q   <= '0;
            mode_q  <= n;
            busy    <= 1'b1;
            state_q <= StIter;
          end
        end
        StIter: begin
          if (!z_q[WIDTH-1]) begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - atan_cur;
          end else begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + atan_cur;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITERS - 1)) state_q <= StPack;
        end
        StPack: begin
          result  <= pk_float;
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: table vectors, random angles against a real-math
// model, clk_en stall equivalence, start-while-busy and mid-operation reset.
module tb_cordic_sincos;

  localparam int unsigned FRACS = 22;
  localparam int unsigned INTS  = 1;
  localparam int unsigned ITERS = FRACS;
  localparam real         PI    = 3.14159265358979323846;
  localparam real         TOL   = 1.0 / (2.0 ** (FRACS - 3));

  logic        clk = 1'b0;
  logic        reset, clk_en, start, n;
  logic [31:0] dataa, result;
  logic        done, busy;

  int checks = 0;
  int errors = 0;

  cordic_sincos #(.FRACS(FRACS), .INTS(INTS), .ITERS(ITERS)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -m : m;
  endfunction

  function automatic real model(input logic sel, input logic [31:0] a);
    real t;
    if (a[30:23] == 8'hFF) begin
      if (a[22:0] != 23'd0) t = 0.0;
      else                  t = a[31] ? -PI / 2.0 : PI / 2.0;
    end else begin
      t = f2r(a);
      if (t >= PI / 2.0)       t = PI / 2.0;
      else if (t <= -PI / 2.0) t = -PI / 2.0;
    end
    return sel ? $sin(t) : $cos(t);
  endfunction

  function automatic logic [31:0] rand_angle();
    logic [31:0] b;
    b[31]    = 1'($urandom_range(1));
    b[30:23] = 8'($urandom_range(128, 100));
    b[22:0]  = 23'($urandom());
    return b;
  endfunction

  task automatic check_u(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_real(input string name, input logic [31:0] res, input real want);
    real d;
    checks++;
    d = f2r(res) - want;
    if (d < 0.0) d = -d;
    if (!(d <= TOL)) begin
      errors++;
      $display("FAIL %s: got %h (%f) want %f", name, res, f2r(res), want);
    end
  endtask

  // Launch one op from idle, optionally stalling clk_en; returns result and edge counts.
  task automatic run_op(input logic sel, input logic [31:0] a, input int stall_pct,
                        output logic [31:0] res, output int edges, output int stalls);
    bit seen;
    n = sel; dataa = a; start = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = ~sel; dataa = $urandom();
    check_u("busy after start", 32'(busy), 32'd1);
    edges = 0; stalls = 0; seen = 0;
    while (!seen && edges < int'(4 * ITERS + 50)) begin
      clk_en = (int'($urandom_range(99)) >= stall_pct);
      if (!clk_en) stalls++;
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1;
    end
    check_u("done seen", 32'(seen), 32'd1);
    res = result;
    clk_en = 1'b1;
    @(posedge clk); #1;
    check_u("done pulse ends", 32'(done), 32'd0);
    check_u("busy ends", 32'(busy), 32'd0);
  endtask

  typedef struct packed {
    logic        sel;
    logic [31:0] a;
    logic [31:0] want;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] r0, r1, a;
    logic        s;
    int          e0, e1, s0, s1, pulses;

    vecs[0]  = '{1'b0, 32'h00000000, 32'h3F800000};
    vecs[1]  = '{1'b1, 32'h3F000000, 32'h3EF57744};
    vecs[2]  = '{1'b0, 32'hBF800000, 32'h3F0A5140};
    vecs[3]  = '{1'b1, 32'hBF000000, 32'hBEF57744};
    vecs[4]  = '{1'b1, 32'h40400000, 32'h3F800000};
    vecs[5]  = '{1'b0, 32'h40400000, 32'h00000000};
    vecs[6]  = '{1'b1, 32'h7F800000, 32'h3F800000};
    vecs[7]  = '{1'b1, 32'hFF800000, 32'hBF800000};
    vecs[8]  = '{1'b1, 32'h7FC00000, 32'h00000000};
    vecs[9]  = '{1'b0, 32'h7FC00000, 32'h3F800000};
    vecs[10] = '{1'b0, 32'h00000001, 32'h3F800000};
    vecs[11] = '{1'b1, 32'hBFC90FDB, 32'hBF800000};
    vecs[12] = '{1'b1, 32'h3F490FDB, 32'h3F3504F3};

    reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = 1'b0; dataa = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_u("reset result", result, 32'd0);
    check_u("reset done", 32'(done), 32'd0);
    check_u("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].a, 0, r0, e0, s0);
      check_real($sformatf("vec%0d value", i), r0, f2r(vecs[i].want));
      check_u($sformatf("vec%0d latency", i), 32'(e0), 32'(ITERS + 1));
    end

    // sin(0): tiny residual, and an exact zero must not carry a sign bit.
    run_op(1'b1, 32'h00000000, 0, r0, e0, s0);
    check_real("sin0 value", r0, 0.0);
    checks++;
    if (r0 == 32'h80000000) begin
      errors++;
      $display("FAIL sin0 sign: got %h want 00000000", r0);
    end

    // Stalled run must match the unstalled one bit-for-bit; delay grows by stalls only.
    for (int k = 0; k < 6; k++) begin
      s = 1'($urandom_range(1));
      a = rand_angle();
      run_op(s, a, 0, r0, e0, s0);
      run_op(s, a, 50, r1, e1, s1);
      check_real($sformatf("stall%0d model", k), r0, model(s, a));
      check_u($sformatf("stall%0d same result", k), r1, r0);
      check_u($sformatf("stall%0d latency", k), 32'(e1), 32'(ITERS + 1 + s1));
    end

    for (int k = 0; k < 20; k++) begin
      s = 1'($urandom_range(1));
      a = rand_angle();
      run_op(s, a, (k % 2) * 25, r0, e0, s0);
      check_real($sformatf("rand%0d %h", k, a), r0, model(s, a));
    end

    // Start held high through an op (including the done cycle): one done, original operands.
    run_op(1'b0, 32'h3F000000, 0, r0, e0, s0);
    n = 1'b0; dataa = 32'h3F000000; start = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    n = 1'b1; dataa = 32'h40400000;
    pulses = 0; r1 = 32'd0;
    for (int i = 0; i < int'(ITERS + 1); i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        r1 = result;
      end
    end
    @(posedge clk); #1;
    check_u("start in done cycle ignored", 32'(busy), 32'd0);
    start = 1'b0;
    for (int i = 0; i < int'(ITERS + 4); i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check_u("busy restart pulses", 32'(pulses), 32'd1);
    check_u("busy restart result", r1, r0);

    // Reset during ITER cycle 5 aborts with cleared outputs and no done.
    n = 1'b1; dataa = 32'h3F000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_u("abort result", result, 32'd0);
    check_u("abort busy", 32'(busy), 32'd0);
    check_u("abort done", 32'(done), 32'd0);
    pulses = 0;
    for (int i = 0; i < int'(ITERS + 5); i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check_u("abort no done", 32'(pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
